// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the active-low 7-segment receive path.
//   Symbol codes, raw active-low segment patterns (bit6..bit0 = a..g) and
//   the scan-receiver FSM state encoding.
package seg7_pkg;

  // Symbol codes reported per digit
  localparam logic [1:0] CODE_UP    = 2'b00;
  localparam logic [1:0] CODE_DOWN  = 2'b01;
  localparam logic [1:0] CODE_BLANK = 2'b10;
  localparam logic [1:0] CODE_UNK   = 2'b11;

  // Active-low segment patterns recognised on the bus
  localparam logic [6:0] SEG_UP_N    = 7'b0011100;
  localparam logic [6:0] SEG_DOWN_N  = 7'b1100010;
  localparam logic [6:0] SEG_BLANK_N = 7'b1111111;

  // Scan receiver FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TRACK  = 2'b01,
    ST_ACCEPT = 2'b10,
    ST_HOLD   = 2'b11
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode -- combinational map of an active-low segment
// pattern onto a 2-bit symbol code (UP, DOWN, BLANK, anything else UNKNOWN).
//   seg_n  in  7  active-low segments, bit6..bit0 = a..g
//   code   out 2  symbol code from seg7_pkg
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [1:0] code
);

  // Exact-match lookup; every unlisted pattern is UNKNOWN.
  always_comb begin
    code = CODE_UNK;
    case (seg_n)
      SEG_UP_N:    code = CODE_UP;
      SEG_DOWN_N:  code = CODE_DOWN;
      SEG_BLANK_N: code = CODE_BLANK;
      default:     code = CODE_UNK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx -- receive end of a multiplexed active-low 7-segment bus.
//   Registers the segment bus and anode selects, waits for a sample to stay
//   identical for STABLE_CYCLES samples, decodes it and reports each change
//   of a digit's accepted symbol exactly once.
// Ports:
//   clk        in   1         system clock
//   rst        in   1         synchronous active-high reset
//   seg_n      in   7         segment bus, active-low, bit6..bit0 = a..g
//   an_n       in   DIGITS    anode selects, active-low, one low = valid
//   sym_valid  out  1         one-cycle pulse: a digit's symbol changed
//   sym_digit  out  3         index of changed digit (held between pulses)
//   sym_code   out  2         new code of that digit (held between pulses)
//   sym_err    out  1         pulse with sym_valid when the code is UNKNOWN
//   sym_table  out  2*DIGITS  accepted code per digit, digit i at [2i+1:2i]
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic                  sym_valid,
  output logic [2:0]            sym_digit,
  output logic [1:0]            sym_code,
  output logic                  sym_err,
  output logic [2*DIGITS-1:0]   sym_table
);

  // The first TRACK compare already sees two identical samples, so ACCEPT is
  // entered once the counter has seen STABLE_CYCLES-2 earlier matches.
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [6:0]          s_seg_q, s_seg_d;
  logic [DIGITS-1:0]   s_an_q,  s_an_d;
  logic [6:0]          p_seg_q, p_seg_d;
  logic [DIGITS-1:0]   p_an_q,  p_an_d;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [2*DIGITS-1:0] table_q, table_d;
  logic                sym_valid_q, sym_valid_d;
  logic                sym_err_q,   sym_err_d;
  logic [2:0]          sym_digit_q, sym_digit_d;
  logic [1:0]          sym_code_q,  sym_code_d;

  logic [3:0]          s_low_cnt_s;
  logic                s_an_ok_s;
  logic                same_s;
  logic [2:0]          p_idx_s;
  logic [1:0]          p_code_s;
  logic [1:0]          cur_code_s;
  logic [CNT_W-1:0]    cnt_inc_s;

  // Previous sample is decoded in ACCEPT: it is the sample that proved
  // stable, even if the current one already moved on.
  seg7_pattern_decode u_decode (
    .seg_n (p_seg_q),
    .code  (p_code_s)
  );

  // Input stage and one-sample history for the stability compare.
  always_comb begin
    s_seg_d = seg_n;
    s_an_d  = an_n;
    p_seg_d = s_seg_q;
    p_an_d  = s_an_q;
  end

  // Anode checks: count low bits of the current sample, locate the low bit of
  // the previous (stable) sample, and fetch that digit's accepted code.
  always_comb begin
    s_low_cnt_s = 4'd0;
    p_idx_s     = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_an_q[i]) s_low_cnt_s = s_low_cnt_s + 4'd1;
      else            s_low_cnt_s = s_low_cnt_s;
      if (!p_an_q[i]) p_idx_s = 3'(i);
      else            p_idx_s = p_idx_s;
    end
    cur_code_s = CODE_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (p_idx_s == 3'(i)) cur_code_s = table_q[2*i +: 2];
      else                  cur_code_s = cur_code_s;
    end
  end

  assign s_an_ok_s = (s_low_cnt_s == 4'd1);
  assign same_s    = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));

  // FSM next state, stability counter, symbol table and report outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    table_d     = table_q;
    sym_valid_d = 1'b0;
    sym_err_d   = 1'b0;
    sym_digit_d = sym_digit_q;
    sym_code_d  = sym_code_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s_an_ok_s) state_d = ST_TRACK;
        else           state_d = ST_IDLE;
      end
      ST_TRACK: begin
        if (!s_an_ok_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!same_s) begin
          state_d = ST_TRACK;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_ACC) begin
          state_d = ST_ACCEPT;
          cnt_d   = cnt_inc_s;
        end else begin
          state_d = ST_TRACK;
          cnt_d   = cnt_inc_s;
        end
      end
      ST_ACCEPT: begin
        if (p_code_s != cur_code_s) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (p_idx_s == 3'(i)) table_d[2*i +: 2] = p_code_s;
            else                  table_d[2*i +: 2] = table_q[2*i +: 2];
          end
          sym_valid_d = 1'b1;
          sym_err_d   = (p_code_s == CODE_UNK);
          sym_digit_d = p_idx_s;
          sym_code_d  = p_code_s;
        end else begin
          table_d = table_q;
        end
        // A change landing on this cycle restarts tracking from zero.
        if (!s_an_ok_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!same_s) begin
          state_d = ST_TRACK;
          cnt_d   = '0;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q;
        end
      end
      ST_HOLD: begin
        if (!s_an_ok_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!same_s) begin
          state_d = ST_TRACK;
          cnt_d   = '0;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sample and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q     <= {7{1'b1}};
      s_an_q      <= {DIGITS{1'b1}};
      p_seg_q     <= {7{1'b1}};
      p_an_q      <= {DIGITS{1'b1}};
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      table_q     <= {DIGITS{CODE_BLANK}};
      sym_valid_q <= 1'b0;
      sym_err_q   <= 1'b0;
      sym_digit_q <= 3'd0;
      sym_code_q  <= CODE_BLANK;
    end else begin
      s_seg_q     <= s_seg_d;
      s_an_q      <= s_an_d;
      p_seg_q     <= p_seg_d;
      p_an_q      <= p_an_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      table_q     <= table_d;
      sym_valid_q <= sym_valid_d;
      sym_err_q   <= sym_err_d;
      sym_digit_q <= sym_digit_d;
      sym_code_q  <= sym_code_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_err   = sym_err_q;
  assign sym_digit = sym_digit_q;
  assign sym_code  = sym_code_q;
  assign sym_table = table_q;

endmodule
